dmem_arbiter: RTL and testbench

Two-requester arbiter and transaction sequencer for the single data-memory port driven by the load/store datapath. It shares the `dmem_*` request/acknowledge bus between the core load/store path (port 0) and a debug/DMA port (port 1). It holds each granted request stable until the memory acknowledges, returns read data and a completion pulse to the owner, and aborts hung transactions with an error after a programmable timeout.

---
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for the shared data-memory port.
// Holds the granted request until ack or timeout, then pulses the owner.
module dmem_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_req_i,
    input  logic [DATA_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_req_i,
    input  logic [DATA_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  dmem_req_o,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    output logic                  dmem_we_o,
    input  logic [DATA_WIDTH-1:0] dmem_rd_i,
    input  logic                  dmem_ack_i,
    output logic                  busy_o
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  we_q, we_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW:0]           cnt_inc;
    logic                  gnt1;
    logic                  tmo;
    logic                  resp;

    // Port 1 wins when alone, or on a tie when port 0 was served last.
    assign gnt1    = m1_req_i && (!m0_req_i || !last_q);
    assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);
    assign tmo     = (TIMEOUT_CYCLES != 0) &&
                     (cnt_inc == (CW+1)'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        owner_d = owner_q;
        last_d  = last_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    owner_d = gnt1;
                    last_d  = gnt1;
                    addr_d  = gnt1 ? m1_addr_i  : m0_addr_i;
                    wdata_d = gnt1 ? m1_wdata_i : m0_wdata_i;
                    we_d    = gnt1 ? m1_we_i    : m0_we_i;
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // An ack in the timeout cycle still completes cleanly.
                if (dmem_ack_i) begin
                    rdata_d = we_q ? '0 : dmem_rd_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    if (!(&cnt_q)) cnt_d = cnt_inc[CW-1:0];
                    if (tmo) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign resp         = (state_q == RESP);
    assign busy_o       = (state_q != IDLE);
    assign dmem_req_o   = (state_q == WAIT);
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign dmem_we_o    = we_q;

    assign m0_ack_o   = resp && !owner_q;
    assign m1_ack_o   = resp && owner_q;
    assign m0_err_o   = m0_ack_o && err_q;
    assign m1_err_o   = m1_ack_o && err_q;
    assign m0_rdata_o = m0_ack_o ? rdata_q : '0;
    assign m1_rdata_o = m1_ack_o ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: loads, stores, contention,
// timeout, reset mid-transaction and stray memory acks.
module tb_dmem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m1_req_i;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic        m0_we_i, m1_we_i;
    logic [31:0] m0_wdata_i, m1_wdata_i;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        m0_ack_o, m1_ack_o;
    logic        m0_err_o, m1_err_o;
    logic        dmem_req_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_we_o;
    logic [31:0] dmem_rd_i;
    logic        dmem_ack_i;
    logic        busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    dmem_arbiter #(
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .m0_req_i    (m0_req_i),
        .m0_addr_i   (m0_addr_i),
        .m0_we_i     (m0_we_i),
        .m0_wdata_i  (m0_wdata_i),
        .m0_rdata_o  (m0_rdata_o),
        .m0_ack_o    (m0_ack_o),
        .m0_err_o    (m0_err_o),
        .m1_req_i    (m1_req_i),
        .m1_addr_i   (m1_addr_i),
        .m1_we_i     (m1_we_i),
        .m1_wdata_i  (m1_wdata_i),
        .m1_rdata_o  (m1_rdata_o),
        .m1_ack_o    (m1_ack_o),
        .m1_err_o    (m1_err_o),
        .dmem_req_o  (dmem_req_o),
        .dmem_addr_o (dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o),
        .dmem_we_o   (dmem_we_o),
        .dmem_rd_i   (dmem_rd_i),
        .dmem_ack_i  (dmem_ack_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i      = 1'b1;
        m0_req_i   = 1'b0;
        m1_req_i   = 1'b0;
        m0_addr_i  = '0;
        m1_addr_i  = '0;
        m0_we_i    = 1'b0;
        m1_we_i    = 1'b0;
        m0_wdata_i = '0;
        m1_wdata_i = '0;
        dmem_rd_i  = '0;
        dmem_ack_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;

        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_dreq", 32'(dmem_req_o), 32'd0);
        chk("rst_daddr", dmem_addr_o, 32'd0);
        chk("rst_acks", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
        chk("rst_rdata0", m0_rdata_o, 32'd0);

        // single port-0 load, three wait cycles
        m0_req_i  = 1'b1;
        m0_addr_i = 32'h100;
        m0_we_i   = 1'b0;
        dmem_rd_i = 32'h1111_2222;
        step();
        chk("ld_dreq_a", 32'(dmem_req_o), 32'd1);
        chk("ld_daddr", dmem_addr_o, 32'h100);
        chk("ld_dwe", 32'(dmem_we_o), 32'd0);
        chk("ld_busy", 32'(busy_o), 32'd1);
        step();
        chk("ld_dreq_b", 32'(dmem_req_o), 32'd1);
        step();
        chk("ld_dreq_c", 32'(dmem_req_o), 32'd1);
        chk("ld_noack", 32'(m0_ack_o), 32'd0);
        dmem_ack_i = 1'b1;
        dmem_rd_i  = 32'hDEAD_BEEF;
        step();
        dmem_ack_i = 1'b0;
        chk("ld_ack", 32'(m0_ack_o), 32'd1);
        chk("ld_rdata", m0_rdata_o, 32'hDEAD_BEEF);
        chk("ld_err", 32'(m0_err_o), 32'd0);
        chk("ld_m1ack", 32'(m1_ack_o), 32'd0);
        chk("ld_dreq_off", 32'(dmem_req_o), 32'd0);
        m0_req_i = 1'b0;
        step();
        chk("ld_ack_once", 32'(m0_ack_o), 32'd0);
        chk("ld_idle", 32'(busy_o), 32'd0);

        // port-1 store with requester inputs changing mid-wait
        m1_req_i   = 1'b1;
        m1_addr_i  = 32'h40;
        m1_wdata_i = 32'h1234_5678;
        m1_we_i    = 1'b1;
        step();
        m1_addr_i  = 32'hFFF;
        m1_wdata_i = 32'h0;
        m1_we_i    = 1'b0;
        chk("st_daddr_a", dmem_addr_o, 32'h40);
        chk("st_dwdata_a", dmem_wdata_o, 32'h1234_5678);
        chk("st_dwe_a", 32'(dmem_we_o), 32'd1);
        step();
        chk("st_daddr_b", dmem_addr_o, 32'h40);
        chk("st_dwdata_b", dmem_wdata_o, 32'h1234_5678);
        chk("st_dwe_b", 32'(dmem_we_o), 32'd1);
        chk("st_m0ack_w", 32'(m0_ack_o), 32'd0);
        dmem_ack_i = 1'b1;
        dmem_rd_i  = 32'hCAFE_F00D;
        step();
        dmem_ack_i = 1'b0;
        chk("st_ack", 32'(m1_ack_o), 32'd1);
        chk("st_rdata", m1_rdata_o, 32'd0);
        chk("st_err", 32'(m1_err_o), 32'd0);
        chk("st_m0ack", 32'(m0_ack_o), 32'd0);
        m1_req_i = 1'b0;
        step();
        chk("st_ack_once", 32'(m1_ack_o), 32'd0);

        // contention with zero-wait memory, fresh from reset
        rst_i = 1'b1;
        step();
        rst_i      = 1'b0;
        m0_req_i   = 1'b1;
        m1_req_i   = 1'b1;
        m0_addr_i  = 32'hA0;
        m1_addr_i  = 32'hB0;
        m0_we_i    = 1'b0;
        m1_we_i    = 1'b0;
        dmem_ack_i = 1'b1;
        dmem_rd_i  = 32'h55;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("ct%0d_addr", i), dmem_addr_o,
                (i % 2 == 0) ? 32'hA0 : 32'hB0);
            step();
            chk($sformatf("ct%0d_ack0", i), 32'(m0_ack_o),
                (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("ct%0d_ack1", i), 32'(m1_ack_o),
                (i % 2 == 0) ? 32'd0 : 32'd1);
            chk($sformatf("ct%0d_rd", i),
                (i % 2 == 0) ? m0_rdata_o : m1_rdata_o, 32'h55);
            step();
            chk($sformatf("ct%0d_idle", i), 32'(busy_o), 32'd0);
        end
        m0_req_i   = 1'b0;
        m1_req_i   = 1'b0;
        dmem_ack_i = 1'b0;
        step();

        // timeout with memory never answering
        m0_req_i  = 1'b1;
        m0_addr_i = 32'h200;
        dmem_rd_i = 32'h99;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("to_wait%0d", i), 32'(dmem_req_o), 32'd1);
            chk($sformatf("to_noack%0d", i), 32'(m0_ack_o), 32'd0);
        end
        step();
        chk("to_ack", 32'(m0_ack_o), 32'd1);
        chk("to_err", 32'(m0_err_o), 32'd1);
        chk("to_rdata", m0_rdata_o, 32'd0);
        chk("to_dreq", 32'(dmem_req_o), 32'd0);
        m0_req_i = 1'b0;
        step();
        chk("to_idle_dreq", 32'(dmem_req_o), 32'd0);
        chk("to_idle_ack", 32'(m0_ack_o), 32'd0);

        // ack lands on the last allowed wait cycle
        m0_req_i = 1'b1;
        step();
        step();
        step();
        step();
        dmem_ack_i = 1'b1;
        dmem_rd_i  = 32'h77;
        step();
        dmem_ack_i = 1'b0;
        chk("tc_ack", 32'(m0_ack_o), 32'd1);
        chk("tc_err", 32'(m0_err_o), 32'd0);
        chk("tc_rdata", m0_rdata_o, 32'h77);
        m0_req_i = 1'b0;
        step();

        // reset mid-wait; last grant was port 0 here
        m0_req_i  = 1'b1;
        m0_addr_i = 32'h300;
        m0_wdata_i = 32'hABCD;
        m0_we_i   = 1'b1;
        step();
        chk("rw_busy", 32'(busy_o), 32'd1);
        rst_i    = 1'b1;
        m0_req_i = 1'b0;
        m0_we_i  = 1'b0;
        step();
        rst_i = 1'b0;
        chk("rw_busy0", 32'(busy_o), 32'd0);
        chk("rw_dreq", 32'(dmem_req_o), 32'd0);
        chk("rw_daddr", dmem_addr_o, 32'd0);
        chk("rw_dwdata", dmem_wdata_o, 32'd0);
        chk("rw_dwe", 32'(dmem_we_o), 32'd0);
        chk("rw_acks", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
        dmem_ack_i = 1'b1;
        dmem_rd_i  = 32'h5A5A;
        step();
        dmem_ack_i = 1'b0;
        chk("rw_late_ack", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
        chk("rw_late_busy", 32'(busy_o), 32'd0);
        m0_req_i  = 1'b1;
        m1_req_i  = 1'b1;
        m0_addr_i = 32'hA0;
        m1_addr_i = 32'hB0;
        step();
        chk("rw_tie_addr", dmem_addr_o, 32'hA0);
        dmem_ack_i = 1'b1;
        step();
        dmem_ack_i = 1'b0;
        chk("rw_tie_ack0", 32'(m0_ack_o), 32'd1);
        chk("rw_tie_ack1", 32'(m1_ack_o), 32'd0);
        m0_req_i = 1'b0;
        m1_req_i = 1'b0;
        step();

        // stray ack while idle
        dmem_ack_i = 1'b1;
        step();
        chk("sa_acks_a", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
        chk("sa_busy_a", 32'(busy_o), 32'd0);
        step();
        dmem_ack_i = 1'b0;
        chk("sa_acks_b", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
        chk("sa_busy_b", 32'(busy_o), 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
